mode_control: RTL and testbench
===============================

Name: mode_control

Overview:
- Holds the processor mode flags E16, E8, M and X. These are the width-mode register written by REP, SEP, PLP, RTI, XCE and XFE.
- Drives the flags to the operand-size decode and also exposes the decoded size_m and size_x.
- When an update narrows the index width, it runs a request/acknowledge handshake with the register file so the upper bits of X and Y are cleared before the instruction retires.
- Sits between the instruction sequencer (command side) and the register file (truncation side).

Parameters:
- none

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command strobe; taken only when ready=1
- cmd  input  3  0=REP, 1=SEP, 2=PLP, 3=XCE, 4=XFE, 5-7 reserved
- operand  input  8  REP/SEP mask or pulled P byte; bit5=M, bit4=X
- carry_in  input  1  current C flag
- overflow_in  input  1  current V flag
- ready  output  1  idle, can take a command
- done  output  1  one-cycle pulse when the command retires
- e16  output  1  mode flag
- e8  output  1  mode flag
- m  output  1  accumulator-narrow flag
- x  output  1  index-narrow flag
- size_m  output  3  SIZE_8/SIZE_16/SIZE_32 per reg_mode.vinc
- size_x  output  3  same encoding
- carry_out  output  1  new C value, valid while carry_we=1
- overflow_out  output  1  new V value, valid while overflow_we=1
- carry_we  output  1  one-cycle C write enable
- overflow_we  output  1  one-cycle V write enable
- trunc_req  output  1  request to clear X/Y bits above trunc_size
- trunc_size  output  3  new index size; held while trunc_req=1
- trunc_ack  input  1  register file has completed the truncation

Behaviour:
- Reset (asynchronous, reset=0):
  - e16=1, e8=1, m=1, x=1, giving size_m=size_x=SIZE_8.
  - ready=1. done, carry_we, overflow_we and trunc_req are 0. carry_out, overflow_out and trunc_size are 0.
  - state=IDLE.
- Size decode is combinational from the registered flags:
  - e16=1, e8=1: size_m=size_x=SIZE_8.
  - e16=1, e8=0: m=0 gives SIZE_16, else SIZE_8; the same rule applies to x.
  - e16=0: size_m is SIZE_32 if (e8=1 and m=0), SIZE_16 if (e8=0 and m=0), SIZE_8 if m=1.
  - e16=0: size_x is SIZE_32 if x=0, else SIZE_8.
- IDLE state:
  - ready=1.
  - When cmd_valid=1, latch cmd, operand, carry_in and overflow_in, set ready=0, and go to APPLY.
- APPLY state (one cycle): compute new flags from the latched values.
  - REP: m &= ~op[5]; x &= ~op[4].
  - SEP: m |= op[5]; x |= op[4].
  - PLP/RTI: m = op[5]; x = op[4].
  - XCE: new e16 = carry_in; carry_out = old e16; carry_we=1.
  - XFE: new e8 = carry_in; new e16 = overflow_in; carry_out = old e8; overflow_out = old e16; carry_we=1; overflow_we=1.
  - Reserved codes: flags unchanged, no write enables.
  - Forcing: if new e16=1 and new e8=1, then m=1 and x=1 regardless of operand. REP cannot widen in W65C02 mode.
  - The flag registers update at the end of APPLY. Write enables pulse during APPLY.
  - If the new size_x is numerically smaller in width than the old size_x, go to TRUNC: trunc_req=1 and trunc_size=new size_x. This covers 32→16, 32→8 and 16→8.
  - Otherwise pulse done and return to IDLE. APPLY-done overlap: done asserts in the cycle after APPLY.
- Latency: command accept in cycle N, flags visible in cycle N+2, done in cycle N+2.
- TRUNC state:
  - Hold trunc_req=1 and trunc_size stable until trunc_ack=1 is sampled.
  - On ack: trunc_req=0 in the next cycle, done pulses in that same cycle, then IDLE.
  - trunc_ack outside TRUNC is ignored.
- cmd_valid while ready=0 is ignored; no queueing.
- Widening (any size increase) never raises trunc_req.
- Size_m narrowing never raises trunc_req; the hidden accumulator bits are preserved.
- Reset asserted in any state returns to the reset values immediately; a pending trunc_req drops.

Test Plan:
- Reset → e16=e8=m=x=1, size_m=size_x=SIZE_8, ready=1, trunc_req=0.
- From reset: XFE with carry_in=0, overflow_in=0, then REP op=0x30 → e16=0, e8=0 and carry_out=1, overflow_out=1 with both write enables pulsed on XFE. After REP: m=0, x=0, size_m=SIZE_16, size_x=SIZE_32, no trunc_req, done at accept+2.
- From the previous state: SEP op=0x10 → trunc_req=1 with trunc_size=SIZE_8. Delay trunc_ack by 3 cycles → trunc_req stays high, ready=0; done arrives one cycle after ack.
- From e16=0, e8=1, m=0: XCE with carry_in=1 → e16=1, carry_out=0. Because e8=1, m and x are forced to 1, giving size_m=SIZE_8 and size_x=SIZE_8. Since x was 0 before (SIZE_32), trunc_req=1 with trunc_size=SIZE_8.
- In W65C02 mode: REP op=0x30 → m=1, x=1 unchanged, done pulses, no trunc_req.
- Assert reset while in TRUNC → trunc_req=0 and flags=1111 immediately. Also pulse cmd_valid while busy → the command is ignored and the flag state is unchanged.

Source files
------------

// File: rtl/mode_control.sv
// mode_control: holds the E16/E8/M/X width-mode flags, decodes operand sizes,
// and runs a truncation handshake with the register file whenever the index
// width narrows.
module mode_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [7:0] operand,
  input  logic       carry_in,
  input  logic       overflow_in,
  output logic       ready,
  output logic       done,
  output logic       e16,
  output logic       e8,
  output logic       m,
  output logic       x,
  output logic [2:0] size_m,
  output logic [2:0] size_x,
  output logic       carry_out,
  output logic       overflow_out,
  output logic       carry_we,
  output logic       overflow_we,
  output logic       trunc_req,
  output logic [2:0] trunc_size,
  input  logic       trunc_ack
);

  // One-hot size codes; numeric order follows width, so a plain '<' on the
  // codes tells whether the index width shrank.
  localparam logic [2:0] SIZE_8  = 3'b001;
  localparam logic [2:0] SIZE_16 = 3'b010;
  localparam logic [2:0] SIZE_32 = 3'b100;

  localparam logic [2:0] CMD_REP = 3'd0;
  localparam logic [2:0] CMD_SEP = 3'd1;
  localparam logic [2:0] CMD_PLP = 3'd2;
  localparam logic [2:0] CMD_XCE = 3'd3;
  localparam logic [2:0] CMD_XFE = 3'd4;

  typedef enum logic [1:0] {IDLE, APPLY, TRUNC} state_t;

  state_t     state, state_d;
  logic [2:0] cmd_q;
  logic       op_m_q, op_x_q, c_q, v_q;
  logic       ne16, ne8, nm, nx, narrow;
  logic [2:0] nsize_x;

  // Only the M and X bits of the operand matter here.
  logic unused_operand;
  assign unused_operand = &{1'b0, operand[7:6], operand[3:0]};

  function automatic logic [2:0] dec_m(input logic fe16, input logic fe8, input logic fm);
    if (fm || (fe16 && fe8)) return SIZE_8;
    if (!fe16 && fe8)        return SIZE_32;
    return SIZE_16;
  endfunction

  function automatic logic [2:0] dec_x(input logic fe16, input logic fe8, input logic fx);
    if (fx || (fe16 && fe8)) return SIZE_8;
    if (fe16)                return SIZE_16;
    return SIZE_32;
  endfunction

  assign size_m  = dec_m(e16, e8, m);
  assign size_x  = dec_x(e16, e8, x);
  assign ready   = (state == IDLE);
  assign nsize_x = dec_x(ne16, ne8, nx);

  // State register, command latch, flag registers and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_q      <= 3'd0;
      op_m_q     <= 1'b0;
      op_x_q     <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      e16        <= 1'b1;
      e8         <= 1'b1;
      m          <= 1'b1;
      x          <= 1'b1;
      done       <= 1'b0;
      trunc_req  <= 1'b0;
      trunc_size <= 3'd0;
    end else begin
      state <= state_d;
      done  <= ((state == APPLY) && !narrow) || ((state == TRUNC) && trunc_ack);
      if ((state == IDLE) && cmd_valid) begin
        cmd_q  <= cmd;
        op_m_q <= operand[5];
        op_x_q <= operand[4];
        c_q    <= carry_in;
        v_q    <= overflow_in;
      end
      if (state == APPLY) begin
        e16 <= ne16;
        e8  <= ne8;
        m   <= nm;
        x   <= nx;
        if (narrow) begin
          trunc_req  <= 1'b1;
          trunc_size <= nsize_x;
        end
      end
      if ((state == TRUNC) && trunc_ack) trunc_req <= 1'b0;
    end
  end

  // Next-state logic plus the new-flag computation and C/V write-back in APPLY.
  always_comb begin
    state_d      = state;
    ne16         = e16;
    ne8          = e8;
    nm           = m;
    nx           = x;
    carry_out    = 1'b0;
    overflow_out = 1'b0;
    carry_we     = 1'b0;
    overflow_we  = 1'b0;
    narrow       = 1'b0;
    case (state)
      IDLE:  if (cmd_valid) state_d = APPLY;
      APPLY: begin
        case (cmd_q)
          CMD_REP: begin nm = m & ~op_m_q; nx = x & ~op_x_q; end
          CMD_SEP: begin nm = m | op_m_q;  nx = x | op_x_q;  end
          CMD_PLP: begin nm = op_m_q;      nx = op_x_q;      end
          CMD_XCE: begin
            ne16      = c_q;
            carry_out = e16;
            carry_we  = 1'b1;
          end
          CMD_XFE: begin
            ne8          = c_q;
            ne16         = v_q;
            carry_out    = e8;
            overflow_out = e16;
            carry_we     = 1'b1;
            overflow_we  = 1'b1;
          end
          default: ;
        endcase
        // Emulation mode pins both widths to 8 bits.
        if (ne16 && ne8) begin
          nm = 1'b1;
          nx = 1'b1;
        end
        narrow  = (nsize_x < size_x);
        state_d = narrow ? TRUNC : IDLE;
      end
      TRUNC: if (trunc_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mode_control.sv
// Bench for mode_control: directed scenarios plus random commands, checked
// against a transaction-level model of the mode flags and operand widths.
module tb_mode_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [7:0] operand = 8'd0;
  logic       carry_in = 1'b0, overflow_in = 1'b0, trunc_ack = 1'b0;
  logic       ready, done, e16, e8, m, x;
  logic [2:0] size_m, size_x, trunc_size;
  logic       carry_out, overflow_out, carry_we, overflow_we, trunc_req;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the architectural flags.
  bit me16 = 1, me8 = 1, mm = 1, mx = 1;

  mode_control dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .operand(operand),
    .carry_in(carry_in), .overflow_in(overflow_in), .ready(ready), .done(done),
    .e16(e16), .e8(e8), .m(m), .x(x), .size_m(size_m), .size_x(size_x),
    .carry_out(carry_out), .overflow_out(overflow_out), .carry_we(carry_we),
    .overflow_we(overflow_we), .trunc_req(trunc_req), .trunc_size(trunc_size),
    .trunc_ack(trunc_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Width in bits of accumulator / index for a flag set.
  function automatic int acc_bits(bit f16, bit f8, bit fm);
    if (f16 && f8) return 8;
    if (fm) return 8;
    if (f16) return 16;
    return f8 ? 32 : 16;
  endfunction

  function automatic int idx_bits(bit f16, bit f8, bit fx);
    if (f16 && f8) return 8;
    if (fx) return 8;
    return f16 ? 16 : 32;
  endfunction

  function automatic logic [2:0] code(int bits);
    case (bits)
      8:  return 3'b001;
      16: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk_flags(input string tag);
    chk({tag, ".flags"}, {e16, e8, m, x}, {me16, me8, mm, mx});
    chk({tag, ".size_m"}, size_m, code(acc_bits(me16, me8, mm)));
    chk({tag, ".size_x"}, size_x, code(idx_bits(me16, me8, mx)));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    me16 = 1; me8 = 1; mm = 1; mx = 1;
    @(posedge clk); #1;
  endtask

  // Issue one command (entered #1 after a clock edge with DUT idle) and check
  // every cycle until it retires. poke injects an ignored command while busy.
  task automatic do_cmd(input int c, input logic [7:0] op, input bit ci, input bit vi,
                        input int dly, input bit poke);
    bit n16, n8, nm, nx, co, vo, cwe, vwe, tr;
    n16 = me16; n8 = me8; nm = mm; nx = mx; co = 0; vo = 0; cwe = 0; vwe = 0;
    case (c)
      0: begin nm = mm && !op[5]; nx = mx && !op[4]; end
      1: begin nm = mm || op[5];  nx = mx || op[4];  end
      2: begin nm = op[5];        nx = op[4];        end
      3: begin co = me16; cwe = 1; n16 = ci; end
      4: begin co = me8; vo = me16; cwe = 1; vwe = 1; n8 = ci; n16 = vi; end
      default: ;
    endcase
    if (n16 && n8) begin nm = 1; nx = 1; end
    tr = idx_bits(n16, n8, nx) < idx_bits(me16, me8, mx);

    cmd_valid = 1'b1; cmd = c[2:0]; operand = op; carry_in = ci; overflow_in = vi;
    @(posedge clk); #1;
    cmd_valid = 1'b0; carry_in = ~ci; overflow_in = ~vi; operand = ~op;
    chk("apply.ready", ready, 0);
    chk("apply.carry_we", carry_we, cwe);
    chk("apply.overflow_we", overflow_we, vwe);
    if (cwe) chk("apply.carry_out", carry_out, co);
    if (vwe) chk("apply.overflow_out", overflow_out, vo);
    chk_flags("apply_old");
    me16 = n16; me8 = n8; mm = nm; mx = nx;
    @(posedge clk); #1;
    chk_flags("post");
    chk("post.carry_we", carry_we, 0);
    if (!tr) begin
      chk("post.done", done, 1);
      chk("post.trunc_req", trunc_req, 0);
      chk("post.ready", ready, 1);
    end else begin
      chk("trunc.req", trunc_req, 1);
      chk("trunc.size", trunc_size, code(idx_bits(n16, n8, nx)));
      chk("trunc.done", done, 0);
      chk("trunc.ready", ready, 0);
      for (int i = 0; i < dly; i++) begin
        if (poke && i == 0) begin cmd_valid = 1'b1; cmd = 3'd4; operand = 8'hff; carry_in = 1'b1; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("wait.req", trunc_req, 1);
        chk("wait.ready", ready, 0);
        chk("wait.done", done, 0);
        chk("wait.size", trunc_size, code(idx_bits(n16, n8, nx)));
      end
      trunc_ack = 1'b1;
      @(posedge clk); #1;
      trunc_ack = 1'b0;
      chk("ack.req", trunc_req, 0);
      chk("ack.done", done, 1);
      chk("ack.ready", ready, 1);
      chk_flags("ack");
    end
    @(posedge clk); #1;
    chk("idle.done", done, 0);
    chk("idle.ready", ready, 1);
    chk_flags("idle");
  endtask

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", ready, 1);
    chk("rst.done", done, 0);
    chk("rst.trunc_req", trunc_req, 0);
    chk("rst.trunc_size", trunc_size, 0);
    chk("rst.we", {carry_we, overflow_we, carry_out, overflow_out}, 0);
    chk_flags("rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Stray ack while idle must be ignored.
    trunc_ack = 1'b1;
    @(posedge clk); #1;
    trunc_ack = 1'b0;
    chk("stray_ack.req", trunc_req, 0);
    chk("stray_ack.done", done, 0);

    // Native mode, then widen both.
    do_cmd(4, 8'h00, 0, 0, 0, 0);
    do_cmd(0, 8'h30, 0, 0, 0, 0);
    // Narrow index 32->8 with a slow ack and an ignored command while busy.
    do_cmd(1, 8'h10, 0, 0, 3, 1);
    // e8=1 with wide index, then XCE into emulation forces narrowing.
    do_cmd(4, 8'h00, 1, 0, 0, 0);
    do_cmd(0, 8'h30, 0, 0, 0, 0);
    do_cmd(3, 8'h00, 1, 0, 1, 0);
    // REP cannot widen in emulation mode.
    do_cmd(0, 8'h30, 0, 0, 0, 0);
    // Reserved code.
    do_cmd(6, 8'hff, 1, 1, 0, 0);

    // Random commands.
    for (int i = 0; i < 60; i++)
      do_cmd($urandom_range(0, 7), 8'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), 1'($urandom));

    // Reset asserted while in TRUNC.
    do_reset();
    do_cmd(4, 8'h00, 0, 0, 0, 0);
    do_cmd(0, 8'h10, 0, 0, 0, 0);
    cmd_valid = 1'b1; cmd = 3'd1; operand = 8'h10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst.req", trunc_req, 1);
    reset = 1'b0;
    #1;
    me16 = 1; me8 = 1; mm = 1; mx = 1;
    chk("async_rst.req", trunc_req, 0);
    chk("async_rst.ready", ready, 1);
    chk_flags("async_rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("after_rst.done", done, 0);
    chk("after_rst.req", trunc_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
